beat_encoder: RTL
=================

// Module: beat_encoder
// PURPOSE
//  Inverse of the beat decode path. Measures how long a raw key is held, in clk cycles.
//  Quantises that length to the nearest beat code (1=4 beats ... 6=1/8 beat).
//  Presents the code on a valid/ready output for the score recorder.
//  Sits between a board push-button and the recorder that later replays codes through the beat decoder.
// PARAMETERS
//  CNT_W      28         width of duration counter and dur_out
//  BEAT_UNIT  5_000_000  cycles in a 1/8 beat; code k nominal length = BEAT_UNIT<<(6-k)
//  MIN_PRESS  2_500_000  presses or gaps shorter than this are glitches and are discarded
// PORTS
//  clk        in   1      system clock
//  rstn       in   1      asynchronous active-low reset
//  en         in   1      1=measure; 0=abandon measurement and return to IDLE
//  key_in     in   1      raw asynchronous key, high = pressed
//  beat_code  out  4      quantised code 1..6
//  dur_out    out  CNT_W  raw measured cycle count (saturated)
//  is_rest    out  1      1 = code describes a gap, not a note
//  code_valid out  1      output word valid; held until accepted
//  code_ready in   1      consumer accepts when code_valid&&code_ready
//  overrun    out  1      1-cycle pulse: new code dropped because previous was unaccepted
// BEHAVIOUR
//  Clocking and reset:
//  - Clock is clk; reset is rstn, asynchronous, active-low.
//  - Reset values: all outputs 0, FSM in IDLE, counters 0, synchroniser 0, first_done=0.
//  - Reset mid-press discards the measurement; no code is emitted.
//  Key synchronisation:
//  - key_in passes through a 2-flop synchroniser to give key_s.
//  - Edges are detected on key_s, so there are 2 cycles of input latency.
//  FSM:
//  - IDLE -> PRESS on a key_s rising edge with en=1. Counter is loaded with 1.
//  - PRESS: counter increments each cycle while key_s=1 and saturates at all-ones (no wrap).
//  - PRESS -> IDLE on a key_s falling edge. The emit step runs in that same cycle.
//  - en=0 in any state returns the FSM to IDLE and clears the counter. A pending code_valid is retained.
//  Quantisation (let U=BEAT_UNIT; the value at a boundary takes the longer code):
//  - cnt < 3U/2 -> 6
//  - cnt < 3U -> 5
//  - cnt < 6U -> 4
//  - cnt < 12U -> 3
//  - cnt < 24U -> 2
//  - otherwise -> 1
//  - Threshold constants are computed at elaboration at CNT_W+1 bits; no runtime multiply.
//  Emit step:
//  - If cnt < MIN_PRESS, nothing is emitted.
//  - If the output is free, load beat_code, dur_out and is_rest, and set code_valid the next cycle.
//  - If code_valid=1 and it is not accepted in the same cycle, the new word is dropped and overrun pulses.
//  - Accept and load in the same cycle: the new word replaces the old one and code_valid stays 1.
//  Output stability:
//  - code_valid falls the cycle after acceptance unless a new word is loaded.
//  - Output data is stable while code_valid=1 and code_ready=0.
// CONFIGURATION
//  REST_ENCODE_EN defined:
//  - In IDLE, a second counter measures the gap since the last release and saturates.
//  - On the next rising edge, the gap is quantised and emitted with is_rest=1, using the same rules, MIN_PRESS filter and overrun handling.
//  - No rest is emitted before the first press after reset or after en falls.
//  REST_ENCODE_EN undefined:
//  - No gap counter exists.
//  - is_rest is tied to 0.
// STRUCTURE
//  Package beat_pkg:
//  - Code localparams BEAT_4=1, BEAT_2=2, BEAT_1=3, BEAT_1_2=4, BEAT_1_4=5, BEAT_1_8=6.
//  - FSM state encoding.
//  - Function quantise(cnt, unit) returning a 4-bit code.
//  Sub-module key_sync: 2-flop synchroniser plus rise/fall pulse outputs. Reused by other key inputs.
//  Everything else is flat in beat_encoder.
// TESTING
//  All cases use BEAT_UNIT=8, MIN_PRESS=4, code_ready=1 unless stated.
//  - Press 8 cycles -> beat_code=6, dur_out=8, is_rest=0, code_valid for 1 cycle.
//  - Presses of 11/12/30/95/96 cycles -> codes 6/5/4/3/2. Boundary values take the longer code.
//  - Press 3 cycles -> no code_valid. Press 1000 cycles -> code 1, dur_out=1000.
//  - code_ready=0, two 8-cycle presses -> first word held unchanged; overrun pulses once at the second release.
//  - Reset asserted mid-press, or en=0 mid-press -> no code emitted; the next 16-cycle press gives code 5.
//  - REST_ENCODE_EN: press 8, gap 40, press 8 -> note 6, then rest 4 (is_rest=1), then note 6.

Source files
------------

// File: rtl/beat_pkg.sv
// Shared beat-code constants, encoder FSM states and the duration-to-code quantiser.
// Codes run from 1 (4 beats) to 6 (1/8 beat). Each step halves the nominal length.
package beat_pkg;

   localparam logic [3:0] BEAT_4   = 4'd1;
   localparam logic [3:0] BEAT_2   = 4'd2;
   localparam logic [3:0] BEAT_1   = 4'd3;
   localparam logic [3:0] BEAT_1_2 = 4'd4;
   localparam logic [3:0] BEAT_1_4 = 4'd5;
   localparam logic [3:0] BEAT_1_8 = 4'd6;

   // Quantiser working width. It must be wider than any duration counter that uses it.
   localparam int QW = 33;

   typedef enum logic {
      ST_IDLE,
      ST_PRESS
   } state_t;

   // Boundaries sit at 1.5x each nominal length, and a value on a boundary takes the longer code.
   // unit is always a constant at the call site, so the thresholds fold to constants.
   function automatic logic [3:0] quantise(input logic [QW-1:0] cnt, input logic [QW-1:0] unit);
      logic [QW-1:0] cnt2;
      cnt2 = cnt << 1;
      if (cnt2 < unit * QW'(3))  return BEAT_1_8;
      if (cnt2 < unit * QW'(6))  return BEAT_1_4;
      if (cnt2 < unit * QW'(12)) return BEAT_1_2;
      if (cnt2 < unit * QW'(24)) return BEAT_1;
      if (cnt2 < unit * QW'(48)) return BEAT_2;
      return BEAT_4;
   endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous key, with one-cycle rise and fall pulses on the synced level.
// Latency is 2 cycles from key_in to key_s. There is no backpressure.
module key_sync (
   input  logic clk,
   input  logic rstn,
   input  logic key_in,
   output logic key_s,
   output logic rise,
   output logic fall
);

   logic meta;
   logic key_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta  <= 1'b0;
         key_s <= 1'b0;
         key_d <= 1'b0;
      end else begin
         meta  <= key_in;
         key_s <= meta;
         key_d <= key_s;
      end
   end

   assign rise = key_s & ~key_d;
   assign fall = ~key_s & key_d;

endmodule

// File: rtl/beat_encoder.sv
// Measures key hold time and emits a quantised beat code. REST_ENCODE_EN also encodes gaps as rests.
// The word is registered 1 cycle after the synced release. code_valid holds until accepted; a new word that arrives while it is held is dropped and overrun pulses.
module beat_encoder #(
   parameter int CNT_W     = 28,
   parameter int BEAT_UNIT = 5_000_000,
   parameter int MIN_PRESS = 2_500_000
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             key_in,
   output logic [3:0]       beat_code,
   output logic [CNT_W-1:0] dur_out,
   output logic             is_rest,
   output logic             code_valid,
   input  logic             code_ready,
   output logic             overrun
);
   import beat_pkg::*;

   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PRESS);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [QW-1:0]    UNIT_Q  = QW'(BEAT_UNIT);

   logic key_s, key_rise, key_fall;

   key_sync u_key_sync (
      .clk    (clk),
      .rstn   (rstn),
      .key_in (key_in),
      .key_s  (key_s),
      .rise   (key_rise),
      .fall   (key_fall)
   );

   state_t           state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (!en) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (key_rise) begin
                  state <= ST_PRESS;
                  cnt   <= CNT_W'(1);
               end
            end
            ST_PRESS: begin
               if (key_fall) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (key_s && cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   logic             emit_note, emit_rest, emit, drop, load;
   logic [CNT_W-1:0] emit_dur;
   logic [3:0]       emit_code;

   assign emit_note = (state == ST_PRESS) && en && key_fall && (cnt >= MIN_CNT);

`ifdef REST_ENCODE_EN
   logic [CNT_W-1:0] gap_cnt;
   logic             first_done;

   // The gap starts on the release cycle, so it reads exactly the low time at the next rise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gap_cnt    <= '0;
         first_done <= 1'b0;
      end else if (!en) begin
         gap_cnt    <= '0;
         first_done <= 1'b0;
      end else if (state == ST_PRESS && key_fall) begin
         gap_cnt    <= CNT_W'(1);
         first_done <= 1'b1;
      end else if (state == ST_IDLE && first_done && !key_s && gap_cnt != CNT_MAX) begin
         gap_cnt <= gap_cnt + CNT_W'(1);
      end
   end

   assign emit_rest = (state == ST_IDLE) && en && key_rise && first_done && (gap_cnt >= MIN_CNT);
   assign emit_dur  = emit_rest ? gap_cnt : cnt;
`else
   assign emit_rest = 1'b0;
   assign emit_dur  = cnt;
`endif

   assign emit      = emit_note | emit_rest;
   assign drop      = emit && code_valid && !code_ready;
   assign load      = emit && !drop;
   assign emit_code = quantise(QW'(emit_dur), UNIT_Q);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_code  <= '0;
         dur_out    <= '0;
         code_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= drop;
         if (load) begin
            beat_code  <= emit_code;
            dur_out    <= emit_dur;
            code_valid <= 1'b1;
         end else if (code_valid && code_ready) begin
            code_valid <= 1'b0;
         end
      end
   end

`ifdef REST_ENCODE_EN
   logic rest_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rest_q <= 1'b0;
      end else if (load) begin
         rest_q <= emit_rest;
      end
   end

   assign is_rest = rest_q;
`else
   assign is_rest = 1'b0;
`endif

endmodule
